// File: rtl/ex_stage_if.sv
// Signal bundle around the execute stage: decode input, memory-stage output,
// data-SRAM request and the controller stall vector/request.
interface ex_stage_if;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    // master: the execute stage itself
    modport master (
        input  stall,
        input  id_to_ex_bus,
        output ex_to_mem_bus,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        output stallreq_for_ex
    );

    // slave: the surrounding pipeline (decode, controller, memory, SRAM)
    modport slave (
        output stall,
        output id_to_ex_bus,
        input  ex_to_mem_bus,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, operand select, 12-op one-hot ALU,
// data-SRAM store request and load-use stall request.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.master  bus
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    logic [158:0] id_to_ex_bus_r;

    // Stall protocol: stall[2] freezes this stage's input register, stall[3]
    // freezes the next stage. If we stop but the next stage moves on, a
    // bubble (all-zero bundle) is inserted; if both stop, the register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_to_ex_bus_r <= '0;
        end else if (bus.stall[2] == STOP && bus.stall[3] == NO_STOP) begin
            id_to_ex_bus_r <= '0;
        end else if (bus.stall[2] == NO_STOP) begin
            id_to_ex_bus_r <= bus.id_to_ex_bus;
        end
    end

    logic [31:0] ex_pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign {ex_pc, inst, alu_op, sel_src1, sel_src2, data_ram_en, data_ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = id_to_ex_bus_r;

    logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic op_or, op_xor, op_sll, op_srl, op_sra, op_lui;

    assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
            op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = alu_op;

    logic sel_sa, sel_pc, sel_rs;
    logic sel_zimm, sel_eight, sel_simm, sel_rt;

    assign {sel_sa, sel_pc, sel_rs}              = sel_src1;
    assign {sel_zimm, sel_eight, sel_simm, sel_rt} = sel_src2;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] sa_zext;

    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'b0, inst[15:0]};
    assign sa_zext  = {27'b0, inst[10:6]};

    logic [31:0] alu_src1;
    logic [31:0] alu_src2;

    // One-hot AND-OR selects: no select bit set yields zero.
    assign alu_src1 = ({32{sel_rs}} & rs_val)
                    | ({32{sel_pc}} & ex_pc)
                    | ({32{sel_sa}} & sa_zext);

    assign alu_src2 = ({32{sel_rt}}    & rt_val)
                    | ({32{sel_simm}}  & imm_sext)
                    | ({32{sel_eight}} & 32'd8)
                    | ({32{sel_zimm}}  & imm_zext);

    logic [4:0]  shamt;
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] and_res;
    logic [31:0] nor_res;
    logic [31:0] or_res;
    logic [31:0] xor_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;

    assign shamt    = alu_src1[4:0];
    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
    assign sltu_res = {31'b0, alu_src1 < alu_src2};
    assign and_res  = alu_src1 & alu_src2;
    assign nor_res  = ~(alu_src1 | alu_src2);
    assign or_res   = alu_src1 | alu_src2;
    assign xor_res  = alu_src1 ^ alu_src2;
    assign sll_res  = alu_src2 << shamt;
    assign srl_res  = alu_src2 >> shamt;
    assign sra_res  = $unsigned($signed(alu_src2) >>> shamt);
    assign lui_res  = {alu_src2[15:0], 16'b0};

    logic [31:0] alu_result;

    // add/sub wrap silently: overflow traps are not part of this core.
    assign alu_result = ({32{op_add}}  & add_res)
                      | ({32{op_sub}}  & sub_res)
                      | ({32{op_slt}}  & slt_res)
                      | ({32{op_sltu}} & sltu_res)
                      | ({32{op_and}}  & and_res)
                      | ({32{op_nor}}  & nor_res)
                      | ({32{op_or}}   & or_res)
                      | ({32{op_xor}}  & xor_res)
                      | ({32{op_sll}}  & sll_res)
                      | ({32{op_srl}}  & srl_res)
                      | ({32{op_sra}}  & sra_res)
                      | ({32{op_lui}}  & lui_res);

    assign bus.ex_to_mem_bus = {ex_pc, data_ram_en, data_ram_wen, sel_rf_res,
                                rf_we, rf_waddr, alu_result};

    assign bus.data_sram_en    = data_ram_en;
    assign bus.data_sram_wen   = data_ram_wen;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rt_val;

    // A load writing a real register: its data only exists after memory,
    // so a dependent instruction in decode must wait one cycle.
    assign bus.stallreq_for_ex = data_ram_en && (data_ram_wen == 4'b0) &&
                                 rf_we && (rf_waddr != 5'd0);

    logic unused_bits;
    assign unused_bits = ^{inst[31:16], inst[5:0], bus.stall[5:4], bus.stall[1:0]};

endmodule
